// File: rtl/conv_out_packer.sv
// Packs the three bit streams of the convolutional encoder into bytes for three lock-step output FIFOs.
// Optional: define CONV_PACK_MSB_FIRST_EN to place the first bit of each byte in bit 7 instead of bit 0.
module conv_out_packer #(
    parameter int unsigned SMALL_SIZE = 1056,
    parameter int unsigned LARGE_SIZE = 6144
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       blk_size,
    input  logic [2:0] d_in,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic [2:0] fifo_full,
    output logic [7:0] q0,
    output logic [7:0] q1,
    output logic [7:0] q2,
    output logic       wrreq,
    output logic       busy,
    output logic       blk_done
);

    localparam int unsigned CNT_W  = 13;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  last_idx;
    logic              size_q;
    logic              pend;
    logic              accept;
    logic              byte_done;
    logic              last_bit;
    logic              fifo_ok;
    logic [BYTE_W-1:0] sr0;
    logic [BYTE_W-1:0] sr1;
    logic [BYTE_W-1:0] sr2;
    logic [BYTE_W-1:0] nb0;
    logic [BYTE_W-1:0] nb1;
    logic [BYTE_W-1:0] nb2;

    assign fifo_ok   = (fifo_full == 3'b000);
    assign last_idx  = size_q ? CNT_W'(LARGE_SIZE - 1) : CNT_W'(SMALL_SIZE - 1);
    assign last_bit  = (bit_cnt == last_idx);
    assign byte_done = (bit_cnt[2:0] == 3'd7);
    assign accept    = d_valid && d_ready;

    // Shift-register contents after accepting the current symbol
`ifdef CONV_PACK_MSB_FIRST_EN
    assign nb0 = {sr0[BYTE_W-2:0], d_in[2]};
    assign nb1 = {sr1[BYTE_W-2:0], d_in[1]};
    assign nb2 = {sr2[BYTE_W-2:0], d_in[0]};
`else
    assign nb0 = {d_in[2], sr0[BYTE_W-1:1]};
    assign nb1 = {d_in[1], sr1[BYTE_W-1:1]};
    assign nb2 = {d_in[0], sr2[BYTE_W-1:1]};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the two handshake strobes; both are gated by reset so nothing leaks during it
    always_comb begin
        state_nxt = state;
        d_ready   = 1'b0;
        wrreq     = reset && pend && fifo_ok;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PACK;
                end
            end
            PACK: begin
                d_ready = reset && (!pend || fifo_ok);
                if (d_valid && reset && (!pend || fifo_ok) && last_bit) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wrreq) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: shift registers, bit counter, output bytes and the single pending-byte flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            size_q   <= 1'b0;
            bit_cnt  <= '0;
            sr0      <= '0;
            sr1      <= '0;
            sr2      <= '0;
            q0       <= '0;
            q1       <= '0;
            q2       <= '0;
            pend     <= 1'b0;
            busy     <= 1'b0;
            blk_done <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            if (state == IDLE && start) begin
                size_q  <= blk_size;
                bit_cnt <= '0;
                sr0     <= '0;
                sr1     <= '0;
                sr2     <= '0;
                busy    <= 1'b1;
            end
            if (accept) begin
                sr0     <= nb0;
                sr1     <= nb1;
                sr2     <= nb2;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (byte_done) begin
                    q0 <= nb0;
                    q1 <= nb1;
                    q2 <= nb2;
                end
            end
            // A new byte cannot complete on the same edge the old one is written
            if (accept && byte_done) begin
                pend <= 1'b1;
            end else if (wrreq) begin
                pend <= 1'b0;
            end
            if (state == DRAIN && wrreq) begin
                busy     <= 1'b0;
                blk_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/conv_out_packer.md
# conv_out_packer

Downstream stage of the bit-serial tail-biting convolutional encoder. Accepts one 3-bit code symbol per cycle (streams d0/d1/d2), packs each stream into bytes, and writes the three bytes in parallel to three output byte FIFOs. Frames exactly one code block of 1056 or 6144 bits per stream, applies backpressure when any output FIFO is full, and flags end of block.

## Interface
Parameters:
- SMALL_SIZE, 1056, bits per stream for blk_size=0 (multiple of 8)
- LARGE_SIZE, 6144, bits per stream for blk_size=1 (multiple of 8)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  single-cycle request to begin a block; honoured only in IDLE
- blk_size  in  1  sampled with start; 0=SMALL_SIZE, 1=LARGE_SIZE
- d_in  in  3  code symbol; d_in[2]=d0, d_in[1]=d1, d_in[0]=d2
- d_valid  in  1  d_in valid
- d_ready  out  1  symbol accepted on edge where d_valid && d_ready
- fifo_full  in  3  full flags of FIFOs 0/1/2
- q0, q1, q2  out  8  packed bytes of streams d0/d1/d2
- wrreq  out  1  common write strobe to all three FIFOs
- busy  out  1  high from start acceptance until block done
- blk_done  out  1  one-cycle pulse after last byte written

## Operation
- States: IDLE, PACK, DRAIN.
- IDLE: d_ready=0. start=1 -> latch size, clear bit counter/shift regs, busy=1, go PACK.
- PACK: each accepted symbol shifts one bit into each of three 8-bit shift regs; bit counter (13 bits) increments. First bit of each byte lands in bit 0 (LSB first).
- On acceptance of 8th bit of a byte: the completed bytes load into q0..q2 and pend flag sets.
- wrreq = pend && (fifo_full==3'b000), combinational; pend clears on that edge. q0..q2 stable while pend=1.
- d_ready = (state==PACK) && (!pend || fifo_full==3'b000). Single pending byte suffices: next byte completes >=8 accepts later.
- Acceptance of bit size-1 -> DRAIN. DRAIN: d_ready=0; when pend clears (wrreq edge), blk_done=1 next cycle, busy=0, go IDLE.
- start in PACK/DRAIN ignored; blk_size changes after start ignored.
- d_valid while d_ready=0: no consumption; upstream holds d_in.
- Any fifo_full bit high blocks the write for all three streams (lock-step).

## Timing
- Reset (reset=0 at edge): state IDLE; d_ready, wrreq, busy, blk_done = 0; q0..q2 = 8'h00; pend, counters, shift regs cleared. Mid-block reset discards pending byte; no wrreq issued.
- start edge N -> busy=1, d_ready=1 in cycle N+1.
- 8th bit accepted at edge M -> q valid and wrreq=1 in cycle M+1 (if not full). Zero bubbles with FIFOs never full: full throughput 1 symbol/cycle.
- Last bit accepted at edge L, FIFOs not full -> wrreq in cycle L+1, blk_done in cycle L+2, d_ready=0 from cycle L+1.
- Per block: exactly size/8 wrreq pulses (132 or 768).

## Configuration
- CONV_PACK_MSB_FIRST_EN: defined -> first bit of each byte lands in bit 7 (MSB first). Undefined -> LSB first as above. No other behaviour changes.

## Test plan
- Small block, FIFOs never full, d_valid constant, streams d0=1,d1=0,d2=alternating 1/0 -> 132 wrreq pulses, q0=8'hFF, q1=8'h00, q2=8'h55; blk_done 2 cycles after last accept; total 1056 accepts.
- Large block, random d_in, compare against bit-reference model -> 768 bytes per stream match, no extra wrreq, busy low after blk_done.
- fifo_full[1]=1 for 20 cycles when byte pending -> wrreq=0, d_ready=0, q0..q2 held; full clears -> single wrreq, packing resumes, no bit lost.
- start asserted during PACK with blk_size=1 on a small block -> ignored; block ends after 1056 bits.
- reset=0 mid-block after 13 bits, then new start -> no wrreq during/after reset, outputs zero, new block packs from bit 0 correctly.
- With CONV_PACK_MSB_FIRST_EN defined, first 8 d0 bits 1,0,0,0,0,0,0,0 -> q0=8'h80 (8'h01 without macro).
